// File: rtl/input_port_ctrl_pkg.sv
// Shared encodings for the input port controller: flit commands and FSM states.
package input_port_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_BODY = 2'b01,
        CMD_HEAD = 2'b10,
        CMD_TAIL = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_DROP = 2'b11
    } state_e;

endpackage

// File: rtl/input_port_ctrl_credit_cnt.sv
// Downstream credit counter: starts full, one credit spent per forwarded flit,
// one returned per credit_in pulse. Saturates at both ends.
module input_port_ctrl_credit_cnt
    import input_port_ctrl_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inc_i,
    input  logic                           dec_i,
    output logic [$clog2(CREDITS+1)-1:0]   count_o,
    output logic                           nonzero_o
);

    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] count_q, count_d;

    // Simultaneous return and spend cancel out; otherwise move one step within 0..CREDITS.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != FULL) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, refilled to full on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/input_port_ctrl.sv
// Router input port controller: requests an output port for each packet at the
// FIFO head, forwards it flit by flit under credit flow control, and discards
// unroutable packets and stray flits.
//
// state | meaning
// IDLE  | waiting for a head flit; stray non-head flits are read and discarded
// REQ   | request registered, waiting for allocator grant; age counts wait
// XFER  | forwarding flits while FIFO has data and a downstream credit exists
// DROP  | draining a packet whose head carried route==0
module input_port_ctrl
    import input_port_ctrl_pkg::*;
#(
    parameter int PORTS   = 4,
    parameter int CREDITS = 4,
    parameter int AGE_W   = 4,
    parameter int AGE_TH  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd_i,
    input  logic             empty_i,
    input  logic [PORTS-1:0] route_i,
    input  logic             grant_i,
    input  logic             credit_in_i,
    output logic             re_o,
    output logic [PORTS-1:0] req_o,
    output logic             age_hi_o,
    output logic             drop_err_o,
    output logic [CNT_W-1:0] pkt_cnt_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_TH);

    state_e           state_q, state_d;
    logic [PORTS-1:0] req_q, req_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             drop_err_q, drop_err_d;

    cmd_e cmd;
    logic head_ok;
    logic route_nz;
    logic tail_rd;
    logic xfer_rd;
    logic credit_nz;

    assign cmd      = cmd_e'(cmd_i);
    assign head_ok  = !empty_i && (cmd == CMD_HEAD);
    assign route_nz = |route_i;
    assign tail_rd  = re_o && (cmd == CMD_TAIL);
    assign xfer_rd  = re_o && (state_q == ST_XFER);

    input_port_ctrl_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (credit_in_i),
        .dec_i     (xfer_rd),
        .count_o   (),
        .nonzero_o (credit_nz)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; grant only matters while requesting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (head_ok) state_d = route_nz ? ST_REQ : ST_DROP;
            ST_REQ:  if (grant_i) state_d = ST_XFER;
            ST_XFER: if (tail_rd) state_d = ST_IDLE;
            ST_DROP: if (tail_rd) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: FIFO read enable, forced low while reset is held.
    always_comb begin
        re_o = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: re_o = !empty_i && (cmd != CMD_HEAD);
                ST_XFER: re_o = !empty_i && credit_nz;
                ST_DROP: re_o = !empty_i;
                default: re_o = 1'b0;
            endcase
        end
    end

    // Next values for request, wait age, packet count and drop pulse.
    // Age counts cycles the request has been visible, including the current one.
    always_comb begin
        req_d      = req_q;
        age_d      = '0;
        pkt_cnt_d  = pkt_cnt_q;
        drop_err_d = 1'b0;
        if (state_q == ST_IDLE && head_ok && route_nz) begin
            req_d = route_i;
        end else if (state_q == ST_XFER && tail_rd) begin
            req_d = '0;
        end
        if (state_q == ST_IDLE && state_d == ST_REQ) begin
            age_d = AGE_W'(1);
        end else if (state_q == ST_REQ && state_d == ST_REQ) begin
            age_d = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
        end
        if (state_q == ST_XFER && tail_rd) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        if (state_q == ST_DROP && tail_rd) begin
            drop_err_d = 1'b1;
        end
    end

    // Registered outputs and age counter; nothing about a packet survives reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            age_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            req_q      <= req_d;
            age_q      <= age_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign req_o      = req_q;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_err_o = drop_err_q;
    assign age_hi_o   = !rst && (state_q == ST_REQ) && (age_q >= AGE_THR);

endmodule
